// File: rtl/font_rom_arbiter.sv
// font_rom_arbiter: shares one synchronous font ROM between two text
// requesters (A = pixel painter, B = background renderer/prefetcher).
// One grant per cycle, fully pipelined; returned font words are steered
// back to the requester that won the corresponding grant.
//
// Handshake: a requester raises *_req with a stable *_addr and keeps both
// unchanged until it sees *_gnt high in the same cycle; the read is then
// accepted and exactly one *_rvalid pulse returns 2+ROM_LAT cycles later.
// An ungranted requester just retries; nothing is queued in here.
module font_rom_arbiter #(
    parameter int ADDR_W     = 11,
    parameter int DATA_W     = 8,
    parameter int ROM_LAT    = 1,
    parameter int STARVE_MAX = 15
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              prio_a,
    input  logic              a_req,
    input  logic [ADDR_W-1:0] a_addr,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic [ADDR_W-1:0] b_addr,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic [ADDR_W-1:0] rom_addr,
    output logic              rom_en,
    input  logic [DATA_W-1:0] font_word,
    output logic              busy
);

    // One tag stage per cycle between the rom_addr register and font_word.
    localparam int         DEPTH        = 1 + ROM_LAT;
    localparam logic [7:0] STARVE_LIMIT = 8'(STARVE_MAX);

    logic             last_b;      // 1 = B won the most recent grant
    logic [7:0]       starve_cnt;  // consecutive denied B cycles in priority mode
    logic [DEPTH-1:0] tag_valid;
    logic [DEPTH-1:0] tag_owner;   // 1 = read belongs to B
    logic             pick_b;      // who wins when both request
    logic             any_gnt;

    // Contention winner: starvation guard in priority mode, alternate otherwise.
    assign pick_b  = prio_a ? (starve_cnt >= STARVE_LIMIT) : ~last_b;

    assign a_gnt   = reset_n & a_req & ~(b_req & pick_b);
    assign b_gnt   = reset_n & b_req & (~a_req | pick_b);
    assign any_gnt = a_gnt | b_gnt;

    assign busy    = |tag_valid;

    // Arbitration history: last winner and the B starvation counter.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            last_b     <= 1'b1;
            starve_cnt <= 8'd0;
        end else begin
            if (any_gnt) begin
                last_b <= b_gnt;
            end
            if (!prio_a || b_gnt) begin
                starve_cnt <= 8'd0;
            end else if (b_req && (starve_cnt < STARVE_LIMIT)) begin
                starve_cnt <= starve_cnt + 8'd1;
            end
        end
    end

    // Issue the winning address to the ROM; address holds when idle.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rom_addr <= '0;
            rom_en   <= 1'b0;
        end else begin
            rom_en <= any_gnt;
            if (any_gnt) begin
                rom_addr <= b_gnt ? b_addr : a_addr;
            end
        end
    end

    // Owner tags travel alongside the read so the last stage lines up with font_word.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag_valid <= '0;
            tag_owner <= '0;
        end else begin
            tag_valid <= {tag_valid[DEPTH-2:0], any_gnt};
            tag_owner <= {tag_owner[DEPTH-2:0], b_gnt};
        end
    end

    // Steer the returning font word to its owner as a one-cycle pulse.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (tag_valid[DEPTH-1]) begin
                if (tag_owner[DEPTH-1]) begin
                    b_rvalid <= 1'b1;
                    b_rdata  <= font_word;
                end else begin
                    a_rvalid <= 1'b1;
                    a_rdata  <= font_word;
                end
            end
        end
    end

endmodule

// File: tb/tb_font_rom_arbiter.sv
// tb_font_rom_arbiter: two instances (ROM_LAT 1 and 3) driven with identical
// stimulus and compared every cycle against a transaction-level model.
module tb_font_rom_arbiter;

    localparam int STARVE_MAX = 15;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // ---------------- shared stimulus ----------------
    logic        prio_a;
    logic        a_req, b_req;
    logic [10:0] a_addr, b_addr;

    // ---------------- per-instance outputs (0: ROM_LAT=1, 1: ROM_LAT=3) ----------------
    logic        a_gnt_v    [2];
    logic        b_gnt_v    [2];
    logic        a_rvalid_v [2];
    logic        b_rvalid_v [2];
    logic [7:0]  a_rdata_v  [2];
    logic [7:0]  b_rdata_v  [2];
    logic [10:0] rom_addr_v [2];
    logic        rom_en_v   [2];
    logic [7:0]  font_word_v[2];
    logic        busy_v     [2];

    font_rom_arbiter #(.ROM_LAT(1), .STARVE_MAX(STARVE_MAX)) dut1 (
        .clk(clk), .reset_n(rst_n), .prio_a(prio_a),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt_v[0]),
        .a_rvalid(a_rvalid_v[0]), .a_rdata(a_rdata_v[0]),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt_v[0]),
        .b_rvalid(b_rvalid_v[0]), .b_rdata(b_rdata_v[0]),
        .rom_addr(rom_addr_v[0]), .rom_en(rom_en_v[0]),
        .font_word(font_word_v[0]), .busy(busy_v[0])
    );

    font_rom_arbiter #(.ROM_LAT(3), .STARVE_MAX(STARVE_MAX)) dut3 (
        .clk(clk), .reset_n(rst_n), .prio_a(prio_a),
        .a_req(a_req), .a_addr(a_addr), .a_gnt(a_gnt_v[1]),
        .a_rvalid(a_rvalid_v[1]), .a_rdata(a_rdata_v[1]),
        .b_req(b_req), .b_addr(b_addr), .b_gnt(b_gnt_v[1]),
        .b_rvalid(b_rvalid_v[1]), .b_rdata(b_rdata_v[1]),
        .rom_addr(rom_addr_v[1]), .rom_en(rom_en_v[1]),
        .font_word(font_word_v[1]), .busy(busy_v[1])
    );

    // ---------------- font ROM models (latency 1 and 3) ----------------
    logic [7:0]  rom [2048];
    logic [10:0] sh1, s3a, s3b, s3c;
    always @(posedge clk) begin
        sh1 <= rom_addr_v[0];
        s3a <= rom_addr_v[1];
        s3b <= s3a;
        s3c <= s3b;
    end
    assign font_word_v[0] = rom[sh1];
    assign font_word_v[1] = rom[s3c];

    // ---------------- scoreboard ----------------
    typedef struct {
        int         issue;  // cycle in which the grant was seen
        bit         owner;  // 1 = B
        logic [7:0] data;
    } ret_t;
    ret_t exp_q[$];

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    bit          model_ok = 0;
    bit          m_last_b;
    int          m_starve;
    bit          m_rom_en;
    logic [10:0] m_rom_addr;
    logic [7:0]  m_last_a_data [2];
    logic [7:0]  m_last_b_data [2];
    bit          a_pend, b_pend;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (cycle %0d): got %h expected %h", tag, cyc, got, exp);
        end
    endtask

    // Compare this cycle's outputs, then advance the model across the coming edge.
    task automatic check_cycle();
        bit ea, eb, bw, va, vb, bz;
        int lat;
        ea = 0;
        eb = 0;
        if (rst_n) begin
            if (a_req && b_req) begin
                bw = prio_a ? (m_starve >= STARVE_MAX) : !m_last_b;
                ea = !bw;
                eb = bw;
            end else begin
                ea = a_req;
                eb = b_req;
            end
        end

        for (int i = 0; i < 2; i++) begin
            lat = (i == 0) ? 1 : 3;
            chk($sformatf("L%0d a_gnt", lat), 32'(a_gnt_v[i]), 32'(ea));
            chk($sformatf("L%0d b_gnt", lat), 32'(b_gnt_v[i]), 32'(eb));
            if (model_ok) begin
                va = 0;
                vb = 0;
                bz = 0;
                foreach (exp_q[k]) begin
                    if (exp_q[k].issue + 2 + lat == cyc) begin
                        if (exp_q[k].owner) begin
                            vb = 1;
                            m_last_b_data[i] = exp_q[k].data;
                        end else begin
                            va = 1;
                            m_last_a_data[i] = exp_q[k].data;
                        end
                    end
                    if ((exp_q[k].issue + 1 <= cyc) && (cyc <= exp_q[k].issue + 1 + lat)) bz = 1;
                end
                chk($sformatf("L%0d a_rvalid", lat), 32'(a_rvalid_v[i]), 32'(va));
                chk($sformatf("L%0d b_rvalid", lat), 32'(b_rvalid_v[i]), 32'(vb));
                chk($sformatf("L%0d a_rdata", lat), 32'(a_rdata_v[i]), 32'(m_last_a_data[i]));
                chk($sformatf("L%0d b_rdata", lat), 32'(b_rdata_v[i]), 32'(m_last_b_data[i]));
                chk($sformatf("L%0d busy", lat), 32'(busy_v[i]), 32'(bz));
                chk($sformatf("L%0d rom_en", lat), 32'(rom_en_v[i]), 32'(m_rom_en));
                chk($sformatf("L%0d rom_addr", lat), 32'(rom_addr_v[i]), 32'(m_rom_addr));
            end
        end

        if (!rst_n) begin
            exp_q.delete();
            m_last_b   = 1;
            m_starve   = 0;
            m_rom_en   = 0;
            m_rom_addr = '0;
            for (int i = 0; i < 2; i++) begin
                m_last_a_data[i] = '0;
                m_last_b_data[i] = '0;
            end
            model_ok = 1;
        end else begin
            m_rom_en = ea | eb;
            if (ea) begin
                exp_q.push_back('{issue: cyc, owner: 1'b0, data: rom[a_addr]});
                m_rom_addr = a_addr;
                m_last_b   = 0;
            end
            if (eb) begin
                exp_q.push_back('{issue: cyc, owner: 1'b1, data: rom[b_addr]});
                m_rom_addr = b_addr;
                m_last_b   = 1;
            end
            if (!prio_a || eb) m_starve = 0;
            else if (b_req && m_starve < STARVE_MAX) m_starve++;
        end
        while (exp_q.size() > 0 && exp_q[0].issue + 5 <= cyc) void'(exp_q.pop_front());

        a_pend = a_req && !ea;
        b_pend = b_req && !eb;
    endtask

    // ---------------- driver ----------------
    task automatic run_cycle();
        @(negedge clk);
        check_cycle();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // mode 0 idle, 1 both fixed addresses, 2 B always + A on odd cycles, 3 random
    task automatic pick_inputs(input int mode);
        if (!a_pend) begin
            case (mode)
                1:       begin a_req = 1; a_addr = 11'h100; end
                2:       begin a_req = cyc[0]; a_addr = 11'($urandom_range(0, 2047)); end
                3:       begin a_req = 1'($urandom_range(0, 1)); a_addr = 11'($urandom_range(0, 2047)); end
                default: a_req = 0;
            endcase
        end
        if (!b_pend) begin
            case (mode)
                1:       begin b_req = 1; b_addr = 11'h200; end
                2:       begin b_req = 1; b_addr = 11'($urandom_range(0, 2047)); end
                3:       begin b_req = 1'($urandom_range(0, 1)); b_addr = 11'($urandom_range(0, 2047)); end
                default: b_req = 0;
            endcase
        end
    endtask

    task automatic run_mode(input int mode, input int n);
        for (int k = 0; k < n; k++) begin
            pick_inputs(mode);
            run_cycle();
        end
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 8'($urandom_range(0, 255));
        rst_n  = 0;
        prio_a = 0;
        a_req  = 0;
        b_req  = 0;
        a_addr = '0;
        b_addr = '0;
        a_pend = 0;
        b_pend = 0;
        @(posedge clk);
        #1;
        run_mode(0, 2);
        rst_n = 1;

        // single A read
        a_req  = 1;
        a_addr = 11'h412;
        run_cycle();
        run_mode(0, 6);

        // round-robin contention
        prio_a = 0;
        run_mode(1, 20);
        // A-priority contention: starvation guard lets B through every 16th grant
        prio_a = 1;
        run_mode(1, 40);
        // A only on odd cycles: B served in the gaps
        run_mode(2, 30);
        run_mode(0, 6);

        // reset in the middle of three in-flight reads
        prio_a = 0;
        run_mode(1, 3);
        rst_n = 0;
        run_mode(1, 1);
        rst_n = 1;
        run_mode(1, 6);
        run_mode(0, 6);

        // random traffic with occasional mode flips
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 15) == 0) prio_a = ~prio_a;
            pick_inputs(3);
            run_cycle();
        end
        run_mode(0, 6);

        // single B read at the top of the ROM
        b_req  = 1;
        b_addr = 11'h7FF;
        run_cycle();
        run_mode(0, 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
